gpr_wb_buf: RTL and testbench
=============================

// Module: gpr_wb_buf
// PURPOSE
//   Write-side initiator for the GPR file: buffers register writebacks from the
//   execute/LSU stages in a small in-order FIFO and drains one entry per cycle
//   into the GPR write port (wr_en/wr_id/wr_data).
//   Provides rs1/rs2 forwarding from not-yet-retired entries so the decode-stage
//   reads, merged with GPR read data, always return the youngest value.
// PARAMETERS
//   DATA_WIDTH  32  width of register data
//   GPRS_WIDTH  5   width of register index
//   DEPTH       4   FIFO entries; power of two, >= 2
// PORTS
//   i_sys_clk       in   1           system clock, rising edge
//   i_sys_rst_n     in   1           asynchronous active-low reset
//   i_wb_valid      in   1           writeback request valid
//   o_wb_ready      out  1           buffer can accept request this cycle
//   i_wb_id         in   GPRS_WIDTH  destination register index
//   i_wb_data       in   DATA_WIDTH  writeback data
//   i_wb_hold       in   1           freeze draining (debug halt / GPR port busy)
//   o_gpr_wr_en     out  1           GPR write enable
//   o_gpr_wr_id     out  GPRS_WIDTH  GPR write index
//   o_gpr_wr_data   out  DATA_WIDTH  GPR write data
//   i_fwd_rs1_id    in   GPRS_WIDTH  rs1 index to look up
//   o_fwd_rs1_hit   out  1           rs1 has a pending write in buffer
//   o_fwd_rs1_data  out  DATA_WIDTH  youngest pending rs1 value (0 if no hit)
//   i_fwd_rs2_id    in   GPRS_WIDTH  rs2 index to look up
//   o_fwd_rs2_hit   out  1           rs2 has a pending write in buffer
//   o_fwd_rs2_data  out  DATA_WIDTH  youngest pending rs2 value (0 if no hit)
//   o_wb_count      out  $clog2(DEPTH)+1  entries currently held
//   o_wb_empty      out  1           o_wb_count == 0
// BEHAVIOUR
//   - Reset (async, i_sys_rst_n low): wr/rd pointers and count cleared, all
//     entry valid bits cleared; o_gpr_wr_en=0, o_gpr_wr_id=0, o_gpr_wr_data=0,
//     fwd hits 0, fwd data 0, o_wb_count=0, o_wb_empty=1, o_wb_ready=1.
//     Reset mid-operation discards all pending entries; none reach the GPR.
//   - Push: accepted on rising edge when i_wb_valid && o_wb_ready. If
//     i_wb_id == 0 the request is accepted (handshake completes) but not stored.
//   - Pop: pop = !o_wb_empty && !i_wb_hold. Write port is combinational from the
//     head entry: o_gpr_wr_en = pop; id/data = head (zeros when !pop). Head
//     retires on the same edge the GPR captures it.
//   - Latency: push into empty buffer -> o_gpr_wr_en high the next cycle.
//   - o_wb_ready = (count < DEPTH) || pop; full and popping accepts a push in
//     the same cycle (count stays DEPTH). Full and held -> ready 0.
//   - Count: +1 on stored push, -1 on pop, unchanged on both or neither.
//     Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
//   - Strict FIFO order; no coalescing of writes to the same index.
//   - Forwarding (combinational): hit when lookup id != 0 and any valid entry
//     (head included) matches; data from youngest matching entry. Incoming
//     request in the same cycle is NOT forwarded. Lookup id 0 -> hit 0, data 0.
//   - Hold: entries retained, forwarding stays active, count cannot decrease.
// TESTING
//   1 reset -> o_wb_empty=1, o_wb_ready=1, o_gpr_wr_en=0, count=0, fwd hits 0.
//   2 push (x5,0xDEADBEEF) into empty -> next cycle wr_en=1, id=5, data=DEADBEEF;
//     cycle after, empty=1.
//   3 hold=1, push x1..x4 (data 0x11..0x44) -> count=4, ready=0, wr_en=0;
//     release hold -> writes x1..x4 in order over 4 cycles, ready=1 first cycle.
//   4 hold=1, push (x7,0xA),(x7,0xB); fwd rs1=7 -> hit=1 data=0xB; rs2=0 -> hit=0.
//   5 push (x0,0x1234) -> handshake completes, count unchanged, no GPR write.
//   6 fill 4 entries under hold, assert rst_n=0 mid-drain -> immediately
//     count=0, wr_en=0; no further writes after release.

Source files
------------

// File: rtl/gpr_wb_buf.sv
// GPR writeback buffer: small in-order FIFO draining one entry per cycle into the
// GPR write port, with rs1/rs2 forwarding of the youngest pending value.
module gpr_wb_buf #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned GPRS_WIDTH = 5,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                    i_sys_clk,
    input  logic                    i_sys_rst_n,
    input  logic                    i_wb_valid,
    output logic                    o_wb_ready,
    input  logic [GPRS_WIDTH-1:0]   i_wb_id,
    input  logic [DATA_WIDTH-1:0]   i_wb_data,
    input  logic                    i_wb_hold,
    output logic                    o_gpr_wr_en,
    output logic [GPRS_WIDTH-1:0]   o_gpr_wr_id,
    output logic [DATA_WIDTH-1:0]   o_gpr_wr_data,
    input  logic [GPRS_WIDTH-1:0]   i_fwd_rs1_id,
    output logic                    o_fwd_rs1_hit,
    output logic [DATA_WIDTH-1:0]   o_fwd_rs1_data,
    input  logic [GPRS_WIDTH-1:0]   i_fwd_rs2_id,
    output logic                    o_fwd_rs2_hit,
    output logic [DATA_WIDTH-1:0]   o_fwd_rs2_data,
    output logic [$clog2(DEPTH):0]  o_wb_count,
    output logic                    o_wb_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [GPRS_WIDTH-1:0] ent_id    [DEPTH];
    logic [DATA_WIDTH-1:0] ent_data  [DEPTH];
    logic [DEPTH-1:0]      ent_valid;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic pop;
    logic push;
    logic store;

    assign o_wb_empty = (count_q == '0);
    assign pop        = !o_wb_empty && !i_wb_hold;
    assign o_wb_ready = (count_q < FULL_CNT) || pop;
    assign push       = i_wb_valid && o_wb_ready;
    // Writes to x0 complete the handshake but are dropped.
    assign store      = push && (i_wb_id != '0);

    assign o_gpr_wr_en   = pop;
    assign o_gpr_wr_id   = pop ? ent_id[rd_ptr_q]   : '0;
    assign o_gpr_wr_data = pop ? ent_data[rd_ptr_q] : '0;
    assign o_wb_count    = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (store) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (store && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !store) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ent_valid <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_id[i]   <= '0;
                ent_data[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            // Clear before set: when full and popping, the new entry reuses the head slot.
            if (pop) begin
                ent_valid[rd_ptr_q] <= 1'b0;
            end
            if (store) begin
                ent_valid[wr_ptr_q] <= 1'b1;
                ent_id[wr_ptr_q]    <= i_wb_id;
                ent_data[wr_ptr_q]  <= i_wb_data;
            end
        end
    end

    // Scan oldest to youngest so the last match wins.
    logic [PTR_W-1:0] scan_idx;

    always_comb begin
        o_fwd_rs1_hit  = 1'b0;
        o_fwd_rs1_data = '0;
        o_fwd_rs2_hit  = 1'b0;
        o_fwd_rs2_data = '0;
        scan_idx       = rd_ptr_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            scan_idx = rd_ptr_q + PTR_W'(i);
            if (ent_valid[scan_idx] && (i_fwd_rs1_id != '0) &&
                (ent_id[scan_idx] == i_fwd_rs1_id)) begin
                o_fwd_rs1_hit  = 1'b1;
                o_fwd_rs1_data = ent_data[scan_idx];
            end
            if (ent_valid[scan_idx] && (i_fwd_rs2_id != '0) &&
                (ent_id[scan_idx] == i_fwd_rs2_id)) begin
                o_fwd_rs2_hit  = 1'b1;
                o_fwd_rs2_data = ent_data[scan_idx];
            end
        end
    end

endmodule

// File: tb/tb_gpr_wb_buf.sv
// Randomised scoreboard bench for gpr_wb_buf against a queue-based reference model.
module tb_gpr_wb_buf;

    localparam int DW    = 32;
    localparam int GW    = 5;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [GW-1:0] id;
        logic [DW-1:0] data;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wb_valid = 1'b0;
    logic          wb_ready;
    logic [GW-1:0] wb_id = '0;
    logic [DW-1:0] wb_data = '0;
    logic          wb_hold = 1'b0;
    logic          wr_en;
    logic [GW-1:0] wr_id;
    logic [DW-1:0] wr_data;
    logic [GW-1:0] rs1_id = '0;
    logic          rs1_hit;
    logic [DW-1:0] rs1_data;
    logic [GW-1:0] rs2_id = '0;
    logic          rs2_hit;
    logic [DW-1:0] rs2_data;
    logic [2:0]    wb_count;
    logic          wb_empty;

    int checks = 0;
    int errors = 0;

    ent_t pend[$];   // reference model contents
    ent_t exp_q[$];  // scoreboard of expected GPR writes

    gpr_wb_buf #(
        .DATA_WIDTH(DW),
        .GPRS_WIDTH(GW),
        .DEPTH     (DEPTH)
    ) dut (
        .i_sys_clk     (clk),
        .i_sys_rst_n   (rst_n),
        .i_wb_valid    (wb_valid),
        .o_wb_ready    (wb_ready),
        .i_wb_id       (wb_id),
        .i_wb_data     (wb_data),
        .i_wb_hold     (wb_hold),
        .o_gpr_wr_en   (wr_en),
        .o_gpr_wr_id   (wr_id),
        .o_gpr_wr_data (wr_data),
        .i_fwd_rs1_id  (rs1_id),
        .o_fwd_rs1_hit (rs1_hit),
        .o_fwd_rs1_data(rs1_data),
        .i_fwd_rs2_id  (rs2_id),
        .o_fwd_rs2_hit (rs2_hit),
        .o_fwd_rs2_data(rs2_data),
        .o_wb_count    (wb_count),
        .o_wb_empty    (wb_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void fwd_model(input logic [GW-1:0] id, output logic hit,
                                      output logic [DW-1:0] data);
        hit  = 1'b0;
        data = '0;
        if (id != 0) begin
            foreach (pend[i]) begin
                if (pend[i].id == id) begin
                    hit  = 1'b1;
                    data = pend[i].data;
                end
            end
        end
    endfunction

    // Monitor: every GPR write must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {27'd0, wr_id, wr_data}, 64'd0);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                check("gpr_wr_id", 64'(wr_id), 64'(e.id));
                check("gpr_wr_data", 64'(wr_data), 64'(e.data));
            end
        end
    end

    // One cycle: drive inputs, check status at negedge, advance the model at posedge.
    task automatic step(input logic v, input logic [GW-1:0] id, input logic [DW-1:0] d,
                        input logic h, input logic [GW-1:0] r1, input logic [GW-1:0] r2);
        logic          pop_m, rdy_m, h1, h2;
        logic [DW-1:0] d1, d2;
        int            sz;
        wb_valid = v;
        wb_id    = id;
        wb_data  = d;
        wb_hold  = h;
        rs1_id   = r1;
        rs2_id   = r2;
        @(negedge clk);
        sz    = pend.size();
        pop_m = (sz > 0) && !h;
        rdy_m = (sz < DEPTH) || pop_m;
        fwd_model(r1, h1, d1);
        fwd_model(r2, h2, d2);
        check("wb_ready", 64'(wb_ready), 64'(rdy_m));
        check("gpr_wr_en", 64'(wr_en), 64'(pop_m));
        check("wb_count", 64'(wb_count), 64'(sz));
        check("wb_empty", 64'(wb_empty), 64'(sz == 0));
        check("rs1_hit", 64'(rs1_hit), 64'(h1));
        check("rs1_data", 64'(rs1_data), 64'(d1));
        check("rs2_hit", 64'(rs2_hit), 64'(h2));
        check("rs2_data", 64'(rs2_data), 64'(d2));
        if (!pop_m) begin
            check("idle_wr_id", 64'(wr_id), 64'd0);
            check("idle_wr_data", 64'(wr_data), 64'd0);
        end
        @(posedge clk);
        if (pop_m) void'(pend.pop_front());
        if (v && rdy_m && id != 0) begin
            pend.push_back('{id: id, data: d});
            exp_q.push_back('{id: id, data: d});
        end
        #1;
    endtask

    initial begin
        #2;
        check("rst_empty", 64'(wb_empty), 64'd1);
        check("rst_ready", 64'(wb_ready), 64'd1);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_count", 64'(wb_count), 64'd0);
        check("rst_rs1_hit", 64'(rs1_hit), 64'd0);
        check("rst_rs2_hit", 64'(rs2_hit), 64'd0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single write into empty buffer.
        step(1, 5, 32'hDEADBEEF, 0, 5, 0);
        step(0, 0, 0, 0, 5, 0);
        step(0, 0, 0, 0, 5, 0);

        // Fill under hold, try a push while full and held, then drain.
        for (int i = 1; i <= 4; i++) step(1, GW'(i), DW'(i * 32'h11), 1, 0, 0);
        step(1, 9, 32'h99, 1, 3, 4);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0);

        // Youngest-match forwarding.
        step(1, 7, 32'hA, 1, 7, 0);
        step(1, 7, 32'hB, 1, 7, 0);
        step(0, 0, 0, 1, 7, 0);
        // Full and popping accepts a push in the same cycle.
        step(1, 3, 32'h33, 1, 7, 3);
        step(1, 6, 32'h66, 1, 6, 3);
        step(1, 8, 32'h88, 0, 7, 8);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 7, 8);

        // Writes to x0 are acknowledged but dropped.
        step(1, 0, 32'h1234, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(99) < 60, GW'($urandom_range(7)), $urandom,
                 $urandom_range(99) < 30, GW'($urandom_range(7)), GW'($urandom_range(7)));
        end
        for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 0, 0, 0, 0);
        check("drain_complete", 64'(exp_q.size()), 64'd0);

        // Reset mid-drain discards everything.
        for (int i = 1; i <= 4; i++) step(1, GW'(i + 10), DW'(i), 1, 0, 0);
        step(0, 0, 0, 0, 12, 13);
        rst_n = 1'b0;
        #1;
        check("mid_rst_count", 64'(wb_count), 64'd0);
        check("mid_rst_wr_en", 64'(wr_en), 64'd0);
        check("mid_rst_empty", 64'(wb_empty), 64'd1);
        check("mid_rst_ready", 64'(wb_ready), 64'd1);
        check("mid_rst_rs1_hit", 64'(rs1_hit), 64'd0);
        check("mid_rst_rs2_data", 64'(rs2_data), 64'd0);
        pend.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 13, 14);
        step(1, 2, 32'hCAFE, 0, 2, 0);
        step(0, 0, 0, 0, 2, 0);
        step(0, 0, 0, 0, 0, 0);
        check("final_drain", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
